hidden_layer_mac: RTL and testbench

- First hidden layer of the DNN; sits directly downstream of the input layer.
- Consumes the four registered inputs and the accompanying ready strobe from that stage.
- Computes four neurons as y[n] = ReLU(bias[n] + sum over k of x[k]*w[n][k]), then applies a shift and saturation.
- Runs sequentially: one input term per cycle, all four neurons in parallel; one result per 6-cycle transaction.

---
 rtl/dnn_pkg.sv | 29 ++
 rtl/neuron_mac.sv | 50 +++++
 rtl/hidden_layer_mac.sv | 122 ++++++++++++
 tb/tb_hidden_layer_mac.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/dnn_pkg.sv
// Shared DNN types and helpers.
// Used by the hidden layers for state encoding and output clamping.
package dnn_pkg;

  localparam int NUM_IN  = 4;
  localparam int NUM_NEU = 4;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    DONE
  } state_t;

  // Clamp to [0, 2^(out_w-1)-1]; caller narrows the result to out_w bits
  function automatic logic signed [31:0] relu_sat(
    input logic signed [31:0] v,
    input int                 out_w
  );
    logic signed [31:0] max_v;
    max_v = (32'sd1 <<< (out_w - 1)) - 32'sd1;
    if (v < 0)
      relu_sat = '0;
    else if (v > max_v)
      relu_sat = max_v;
    else
      relu_sat = v;
  endfunction

endpackage

// File: rtl/neuron_mac.sv
// Single neuron: bias load, one MAC term per step,
// shift/ReLU/saturate into the output register on fire.
module neuron_mac
  import dnn_pkg::*;
#(
  parameter int input_width  = 5,
  parameter int weight_width = 5,
  parameter int output_width = 7,
  parameter int frac_shift   = 0,
  parameter int acc_width    = input_width + weight_width + 3
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           load,
  input  logic                           step,
  input  logic                           fire,
  input  logic signed [weight_width-1:0] bias,
  input  logic signed [input_width-1:0]  x,
  input  logic signed [weight_width-1:0] w,
  output logic signed [output_width-1:0] y
);

  localparam int PW = input_width + weight_width;

  logic signed [PW-1:0]        prod;
  logic signed [acc_width-1:0] prod_ext;
  logic signed [acc_width-1:0] bias_ext;
  logic signed [acc_width-1:0] acc;
  logic signed [acc_width-1:0] shifted;

  assign prod     = x * w;
  assign prod_ext = {{(acc_width-PW){prod[PW-1]}}, prod};
  assign bias_ext = {{(acc_width-weight_width){bias[weight_width-1]}}, bias};
  assign shifted  = acc >>> frac_shift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      y   <= '0;
    end else begin
      if (load)
        acc <= bias_ext;
      else if (step)
        acc <= acc + prod_ext;
      if (fire)
        y <= output_width'(relu_sat(32'(shifted), output_width));
    end
  end

endmodule

// File: rtl/hidden_layer_mac.sv
// First hidden layer: four neurons sharing one FSM and term counter,
// one input term per cycle, result every 6 cycles.
module hidden_layer_mac
  import dnn_pkg::*;
#(
  parameter int input_width  = 5,
  parameter int weight_width = 5,
  parameter int output_width = 7,
  parameter int frac_shift   = 0,
  parameter int acc_width    = input_width + weight_width + 3
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              input_ready,
  input  logic signed [input_width-1:0]     in0,
  input  logic signed [input_width-1:0]     in1,
  input  logic signed [input_width-1:0]     in2,
  input  logic signed [input_width-1:0]     in3,
  input  logic [16*weight_width-1:0]        weights,
  input  logic [4*weight_width-1:0]         biases,
  output logic signed [output_width-1:0]    out0,
  output logic signed [output_width-1:0]    out1,
  output logic signed [output_width-1:0]    out2,
  output logic signed [output_width-1:0]    out3,
  output logic                              output_ready,
  output logic                              busy
);

  state_t state, next_state;
  logic [1:0] k;
  logic load, step, fire;

  logic signed [input_width-1:0]  x_q [NUM_IN];
  logic signed [weight_width-1:0] w_q [NUM_NEU][NUM_IN];
  logic signed [output_width-1:0] y   [NUM_NEU];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    load       = 1'b0;
    step       = 1'b0;
    fire       = 1'b0;
    unique case (state)
      IDLE: begin
        if (input_ready) begin
          load       = 1'b1;
          next_state = ACC;
        end
      end
      ACC: begin
        step = 1'b1;
        if (k == 2'(NUM_IN - 1))
          next_state = DONE;
      end
      DONE: begin
        fire       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k            <= '0;
      output_ready <= 1'b0;
      for (int i = 0; i < NUM_IN; i++)
        x_q[i] <= '0;
      for (int n = 0; n < NUM_NEU; n++)
        for (int j = 0; j < NUM_IN; j++)
          w_q[n][j] <= '0;
    end else begin
      output_ready <= fire;
      if (load) begin
        k      <= '0;
        x_q[0] <= in0;
        x_q[1] <= in1;
        x_q[2] <= in2;
        x_q[3] <= in3;
        for (int n = 0; n < NUM_NEU; n++)
          for (int j = 0; j < NUM_IN; j++)
            w_q[n][j] <= weights[(n*NUM_IN+j)*weight_width +: weight_width];
      end else if (step) begin
        k <= k + 2'd1;
      end
    end
  end

  // Bias goes straight into each accumulator on the capture edge
  for (genvar n = 0; n < NUM_NEU; n++) begin : g_neu
    neuron_mac #(
      .input_width (input_width),
      .weight_width(weight_width),
      .output_width(output_width),
      .frac_shift  (frac_shift),
      .acc_width   (acc_width)
    ) u_neu (
      .clk  (clk),
      .rst_n(rst_n),
      .load (load),
      .step (step),
      .fire (fire),
      .bias (biases[n*weight_width +: weight_width]),
      .x    (x_q[k]),
      .w    (w_q[n][k]),
      .y    (y[n])
    );
  end

  assign out0 = y[0];
  assign out1 = y[1];
  assign out2 = y[2];
  assign out3 = y[3];
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_hidden_layer_mac.sv
// Scoreboard bench for hidden_layer_mac: directed vectors,
// expectations queued at capture, checked when output_ready fires.
module tb_hidden_layer_mac;

  typedef struct {
    int y0;
    int y1;
    int y2;
    int y3;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ir_a = 1'b0;
  logic ir_b = 1'b0;
  logic signed [4:0] in0 = '0, in1 = '0, in2 = '0, in3 = '0;
  logic [79:0] weights = '0;
  logic [19:0] biases = '0;

  logic signed [6:0] a0, a1, a2, a3, b0, b1, b2, b3;
  logic ordy_a, busy_a, ordy_b, busy_b;

  exp_t q_a[$];
  exp_t q_b[$];
  int checks = 0;
  int fails = 0;

  always #5 clk = ~clk;

  hidden_layer_mac dut_a (
    .clk(clk), .rst_n(rst_n), .input_ready(ir_a),
    .in0(in0), .in1(in1), .in2(in2), .in3(in3),
    .weights(weights), .biases(biases),
    .out0(a0), .out1(a1), .out2(a2), .out3(a3),
    .output_ready(ordy_a), .busy(busy_a)
  );

  hidden_layer_mac #(.frac_shift(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .input_ready(ir_b),
    .in0(in0), .in1(in1), .in2(in2), .in3(in3),
    .weights(weights), .biases(biases),
    .out0(b0), .out1(b1), .out2(b2), .out3(b3),
    .output_ready(ordy_b), .busy(busy_b)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [79:0] w_fill(input int v);
    logic [79:0] r;
    r = '0;
    for (int i = 0; i < 16; i++)
      r[i*5 +: 5] = 5'(v);
    return r;
  endfunction

  function automatic logic [19:0] b_pack(input int v0, input int v1,
                                         input int v2, input int v3);
    logic [19:0] r;
    r = {5'(v3), 5'(v2), 5'(v1), 5'(v0)};
    return r;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (ordy_a === 1'b1) begin
      if (q_a.size() == 0) begin
        chk("unexpected_ready_a", 1, 0);
      end else begin
        e = q_a.pop_front();
        chk("a_out0", int'(a0), e.y0);
        chk("a_out1", int'(a1), e.y1);
        chk("a_out2", int'(a2), e.y2);
        chk("a_out3", int'(a3), e.y3);
      end
    end
    if (ordy_b === 1'b1) begin
      if (q_b.size() == 0) begin
        chk("unexpected_ready_b", 1, 0);
      end else begin
        e = q_b.pop_front();
        chk("b_out0", int'(b0), e.y0);
        chk("b_out1", int'(b1), e.y1);
        chk("b_out2", int'(b2), e.y2);
        chk("b_out3", int'(b3), e.y3);
      end
    end
  end

  task automatic issue(input int x0, input int x1, input int x2, input int x3,
                       input logic [79:0] w, input logic [19:0] b,
                       input int e0, input int e1, input int e2, input int e3,
                       input string tag);
    exp_t e;
    int cnt;
    bit got;
    @(negedge clk);
    in0 = 5'(x0); in1 = 5'(x1); in2 = 5'(x2); in3 = 5'(x3);
    weights = w;
    biases = b;
    ir_a = 1'b1;
    @(posedge clk);
    e = '{e0, e1, e2, e3};
    q_a.push_back(e);
    @(negedge clk);
    ir_a = 1'b0;
    cnt = 0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (ordy_a) got = 1'b1;
      else begin
        if (busy_a) cnt++;
        @(negedge clk);
      end
    end
    chk({tag, "_ready_seen"}, int'(got), 1);
    chk({tag, "_busy_cycles"}, cnt, 5);
    chk({tag, "_busy_during_ready"}, int'(busy_a), 0);
    @(negedge clk);
    chk({tag, "_pulse_width"}, int'(ordy_a), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    logic [79:0] w6;
    repeat (3) @(negedge clk);
    chk("rst_out0", int'(a0), 0);
    chk("rst_out3", int'(a3), 0);
    chk("rst_ready", int'(ordy_a), 0);
    chk("rst_busy", int'(busy_a), 0);
    chk("rst_b_out1", int'(b1), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    issue(1, 2, 3, 4, w_fill(1), '0, 10, 10, 10, 10, "basic");
    issue(-1, -2, -3, -4, w_fill(1), b_pack(3, 0, 0, 0), 0, 0, 0, 0, "relu");
    issue(15, 15, 15, 15, w_fill(15), '0, 63, 63, 63, 63, "sat_pos");
    issue(-16, -16, -16, -16, w_fill(-16), '0, 63, 63, 63, 63, "sat_neg");

    // input_ready held high; captures only at 0, 6, 12, 18
    @(negedge clk);
    weights = w_fill(1);
    biases = '0;
    ir_a = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in0 = 5'(i % 8);
      in1 = 5'(i % 8 + 1);
      in2 = 5'(i % 8 + 2);
      in3 = 5'(i % 8 + 3);
      @(posedge clk);
      if (i % 6 == 0) begin
        e.y0 = 4 * (i % 8) + 6;
        e.y1 = e.y0; e.y2 = e.y0; e.y3 = e.y0;
        q_a.push_back(e);
      end
      @(negedge clk);
    end
    ir_a = 1'b0;
    repeat (12) @(negedge clk);
    chk("held_all_done", q_a.size(), 0);

    // reset in the middle of accumulation
    in0 = 5'(1); in1 = 5'(2); in2 = 5'(3); in3 = 5'(4);
    weights = w_fill(1);
    ir_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ir_a = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_out0", int'(a0), 0);
    chk("abort_out2", int'(a2), 0);
    chk("abort_ready", int'(ordy_a), 0);
    chk("abort_busy", int'(busy_a), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("abort_idle_busy", int'(busy_a), 0);
    issue(2, 2, 2, 2, w_fill(1), '0, 8, 8, 8, 8, "post_reset");

    // frac_shift=2 instance, distinct weight row per neuron
    w6 = '0;
    for (int k = 0; k < 4; k++) begin
      w6[(0*4+k)*5 +: 5] = 5'(1);
      w6[(1*4+k)*5 +: 5] = 5'(k + 1);
      w6[(2*4+k)*5 +: 5] = 5'(2);
      w6[(3*4+k)*5 +: 5] = 5'(0);
    end
    @(negedge clk);
    in0 = 5'(4); in1 = 5'(4); in2 = 5'(4); in3 = 5'(4);
    weights = w6;
    biases = b_pack(0, -1, 0, 12);
    ir_b = 1'b1;
    @(posedge clk);
    e = '{4, 9, 8, 3};
    q_b.push_back(e);
    @(negedge clk);
    ir_b = 1'b0;
    repeat (10) @(negedge clk);

    chk("q_a_drained", q_a.size(), 0);
    chk("q_b_drained", q_b.size(), 0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
